// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM state type and default widths for the serial
// sequence detector.
package seq_det_pkg;

   localparam int unsigned PAT_W_DEF = 8;
   localparam int unsigned CNT_W_DEF = 16;
   localparam int unsigned WIN_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } seq_state_e;

endpackage

// File: rtl/seq_det_shift.sv
// seq_det_shift: serial history register plus masked pattern comparison.
// hit compares the low `len` bits of {history, in_bit} against the pattern;
// bit 0 of the candidate is the bit currently being presented.
module seq_det_shift
   import seq_det_pkg::*;
#(
   parameter int unsigned PAT_W = PAT_W_DEF,
   parameter int unsigned LEN_W = $clog2(PAT_W) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             shift_en,
   input  logic             in_bit,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   output logic             hit
);

   logic [PAT_W-1:0] history_q, history_d;
   logic [PAT_W-1:0] cand;
   logic [PAT_W-1:0] mask;

   // Candidate word, length mask, comparison and next history.
   always_comb begin
      cand = (history_q << 1) | PAT_W'(in_bit);
      mask = '0;
      for (int unsigned i = 0; i < PAT_W; i++) begin
         mask[i] = (i < 32'(len));
      end
      hit = (((cand ^ pattern) & mask) == '0);
      history_d = history_q;
      if (clear) begin
         history_d = '0;
      end else if (shift_en) begin
         history_d = cand;
      end
   end

   // History register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         history_q <= '0;
      end else begin
         history_q <= history_d;
      end
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: run-controlled serial pattern detector with match counter.
// Optional feature: define SEQ_DET_IRQ_EN to add a sticky irq output set by
// done and cleared by irq_clr (clear wins).
module seq_detect_ctrl
   import seq_det_pkg::*;
#(
   parameter int unsigned PAT_W = PAT_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF,
   parameter int unsigned WIN_W = WIN_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   stop,
   input  logic                   in_valid,
   input  logic                   in,
   input  logic [PAT_W-1:0]       cfg_pattern,
   input  logic [$clog2(PAT_W):0] cfg_len,
   input  logic                   cfg_overlap,
   input  logic [WIN_W-1:0]       cfg_window,
   output logic                   busy,
   output logic                   match,
   output logic [CNT_W-1:0]       match_count,
`ifdef SEQ_DET_IRQ_EN
   input  logic                   irq_clr,
   output logic                   irq,
`endif
   output logic                   done
);

   localparam int unsigned LEN_W = $clog2(PAT_W) + 1;

   seq_state_e       state_q, state_d;
   logic [PAT_W-1:0] pattern_q, pattern_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             overlap_q, overlap_d;
   logic [WIN_W-1:0] window_q, window_d;
   logic [LEN_W-1:0] fill_q, fill_d;
   logic [WIN_W-1:0] bitcnt_q, bitcnt_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             shift_clear;
   logic             shift_en;
   logic             hit;

   seq_det_shift #(
      .PAT_W (PAT_W),
      .LEN_W (LEN_W)
   ) u_shift (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (shift_clear),
      .shift_en (shift_en),
      .in_bit   (in),
      .pattern  (pattern_q),
      .len      (len_q),
      .hit      (hit)
   );

   // Next-state, counters, config latch and Mealy match output.
   always_comb begin
      state_d     = state_q;
      pattern_d   = pattern_q;
      len_d       = len_q;
      overlap_d   = overlap_q;
      window_d    = window_q;
      fill_d      = fill_q;
      bitcnt_d    = bitcnt_q;
      count_d     = count_q;
      shift_clear = 1'b0;
      shift_en    = (state_q == RUN) && in_valid;
      match       = (state_q == RUN) && in_valid &&
                    (fill_q >= (len_q - LEN_W'(1))) && hit;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ARM;
            end
         end
         ARM: begin
            pattern_d = cfg_pattern;
            overlap_d = cfg_overlap;
            window_d  = cfg_window;
            if (cfg_len == '0) begin
               len_d = LEN_W'(1);
            end else if (cfg_len > LEN_W'(PAT_W)) begin
               len_d = LEN_W'(PAT_W);
            end else begin
               len_d = cfg_len;
            end
            fill_d      = '0;
            bitcnt_d    = '0;
            count_d     = '0;
            shift_clear = 1'b1;
            state_d     = RUN;
         end
         RUN: begin
            if (in_valid) begin
               bitcnt_d = bitcnt_q + WIN_W'(1);
               if (match && !overlap_q) begin
                  fill_d = '0;
               end else if (fill_q < len_q) begin
                  fill_d = fill_q + LEN_W'(1);
               end
               if (match && (count_q != '1)) begin
                  count_d = count_q + CNT_W'(1);
               end
            end
            // A bit arriving with stop, or the last window bit, is counted first.
            if (stop || (in_valid && (window_q != '0) && (bitcnt_d == window_q))) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, latched configuration and counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         pattern_q <= '0;
         len_q     <= LEN_W'(1);
         overlap_q <= 1'b0;
         window_q  <= '0;
         fill_q    <= '0;
         bitcnt_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         pattern_q <= pattern_d;
         len_q     <= len_d;
         overlap_q <= overlap_d;
         window_q  <= window_d;
         fill_q    <= fill_d;
         bitcnt_q  <= bitcnt_d;
         count_q   <= count_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign match_count = count_q;

`ifdef SEQ_DET_IRQ_EN
   logic irq_q, irq_d;

   // Sticky interrupt: set by done, clear has priority.
   always_comb begin
      irq_d = irq_q;
      if (irq_clr) begin
         irq_d = 1'b0;
      end else if (state_q == DONE) begin
         irq_d = 1'b1;
      end
   end

   // Interrupt flag register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq = irq_q;
`endif

endmodule
